// File: rtl/stepdown_gate_sequencer.sv
// Break-before-make gate sequencer for the stepdown stage: per-period PWM with
// dead time, cycle-by-cycle over-current truncation and a latched OCP fault.
module stepdown_gate_sequencer #(
  parameter int CNT_W     = 8,
  parameter int DT_W      = 4,
  parameter int OCP_LIMIT = 4
) (
  input  logic             CELCLK,
  input  logic             CELRSTN,
  input  logic             en,
  input  logic [CNT_W-1:0] period,
  input  logic [CNT_W-1:0] duty,
  input  logic [DT_W-1:0]  deadtime,
  input  logic             ocp,
  output logic             hs_on,
  output logic             ls_on,
  output logic             cycle_start,
  output logic             cfg_err,
  output logic             fault,
  output logic             busy,
  output logic [2:0]       state_dbg
);

  localparam int XW = CNT_W + 2;
  localparam int OW = $clog2(OCP_LIMIT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DT1   = 3'd1,
    HS    = 3'd2,
    DT2   = 3'd3,
    LS    = 3'd4,
    FAULT = 3'd5
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] pcnt;
  logic [DT_W-1:0]  ph;
  logic [CNT_W-1:0] p_q;
  logic [DT_W-1:0]  t_q;
  logic [CNT_W-1:0] hs_last_q;
  logic             trunc_q;
  logic             shut_q;
  logic [OW-1:0]    ocnt_q, ocnt_n;

  logic             start, cfg_bad, period_end, enter_dt2, shut_set, ocp_hit;

  // Config evaluated from the live inputs; only used at a period start.
  logic [DT_W-1:0]  t_eff;
  logic [XW-1:0]    need, avail;
  logic             cfg_ok;
  logic [CNT_W-1:0] h_new, hs_last_new;

  always_comb begin
    t_eff       = (deadtime == '0) ? DT_W'(1) : deadtime;
    need        = XW'({t_eff, 1'b0}) + XW'(2);
    cfg_ok      = (XW'(period) >= need);
    avail       = XW'(period) - need + XW'(1);
    h_new       = (XW'(duty) < avail) ? duty : CNT_W'(avail);
    hs_last_new = CNT_W'(t_eff) + h_new - CNT_W'(1);
  end

  always_comb begin
    state_n    = state;
    ocnt_n     = ocnt_q;
    start      = 1'b0;
    cfg_bad    = 1'b0;
    period_end = 1'b0;
    enter_dt2  = 1'b0;
    shut_set   = 1'b0;
    ocp_hit    = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          if (cfg_ok) start = 1'b1;
          else        cfg_bad = 1'b1;
        end
      end
      DT1: begin
        if (!en)                                      state_n = IDLE;
        else if (pcnt == CNT_W'(t_q) - CNT_W'(1))     state_n = HS;
      end
      HS: begin
        if (!en) begin
          state_n   = DT2;
          enter_dt2 = 1'b1;
          shut_set  = 1'b1;
        end else if (ocp) begin
          state_n   = DT2;
          enter_dt2 = 1'b1;
          ocp_hit   = 1'b1;
        end else if (pcnt == hs_last_q) begin
          state_n   = DT2;
          enter_dt2 = 1'b1;
        end
      end
      DT2: begin
        // A shutdown dead time always runs to completion before IDLE.
        if (shut_q) begin
          if (ph == t_q - DT_W'(1)) state_n = IDLE;
        end else if (!en) begin
          state_n = IDLE;
        end else if (ph == t_q - DT_W'(1)) begin
          state_n = LS;
        end
      end
      LS: begin
        if (!en)                              state_n = IDLE;
        else if (pcnt == p_q - CNT_W'(1))     period_end = 1'b1;
      end
      FAULT: begin
        if (!en) begin
          state_n = IDLE;
          ocnt_n  = '0;
        end
      end
      default: state_n = IDLE;
    endcase

    if (period_end) begin
      ocnt_n = trunc_q ? ocnt_q + OW'(1) : '0;
      if (ocnt_n == OW'(OCP_LIMIT)) begin
        state_n = FAULT;
      end else if (cfg_ok) begin
        start = 1'b1;
      end else begin
        cfg_bad = 1'b1;
        state_n = IDLE;
      end
    end

    if (start) state_n = (duty == '0) ? LS : DT1;
  end

  always_ff @(posedge CELCLK or negedge CELRSTN) begin
    if (!CELRSTN) begin
      state       <= IDLE;
      pcnt        <= '0;
      ph          <= '0;
      p_q         <= '0;
      t_q         <= '0;
      hs_last_q   <= '0;
      trunc_q     <= 1'b0;
      shut_q      <= 1'b0;
      ocnt_q      <= '0;
      hs_on       <= 1'b0;
      ls_on       <= 1'b0;
      cycle_start <= 1'b0;
      cfg_err     <= 1'b0;
      fault       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state  <= state_n;
      ocnt_q <= ocnt_n;
      if (start) begin
        p_q       <= period;
        t_q       <= t_eff;
        hs_last_q <= hs_last_new;
        pcnt      <= '0;
        trunc_q   <= 1'b0;
      end else begin
        pcnt <= pcnt + CNT_W'(1);
        if (ocp_hit) trunc_q <= 1'b1;
      end
      ph <= enter_dt2 ? '0 : ph + DT_W'(1);
      if (shut_set)               shut_q <= 1'b1;
      else if (state_n == IDLE)   shut_q <= 1'b0;
      // Outputs are registered copies of the next-state decode.
      hs_on       <= (state_n == HS);
      ls_on       <= (state_n == LS);
      cycle_start <= start;
      cfg_err     <= cfg_bad;
      fault       <= (state_n == FAULT);
      busy        <= (state_n != IDLE) && (state_n != FAULT);
    end
  end

  assign state_dbg = state;

endmodule
